// File: rtl/majority_voter_seq_if.sv
// Bus bundle for majority_voter_seq: sample controls in, filtered decision and diagnostics out.
// The master drives the voter inputs; the slave is the voter itself.
interface majority_voter_seq_if #(
  parameter int N     = 5,
  parameter int CNT_W = 8
);
  logic             en;
  logic [N-1:0]     in_vec;
  logic             clr_cnt;
  logic             vote_out;
  logic             valid;
  logic             flip;
  logic [N-1:0]     mismatch;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output en, in_vec, clr_cnt,
    input  vote_out, valid, flip, mismatch, err_cnt
  );

  modport slave (
    input  en, in_vec, clr_cnt,
    output vote_out, valid, flip, mismatch, err_cnt
  );
endinterface

// File: rtl/majority_voter_seq.sv
// N-input majority voter with a HOLD-cycle persistence filter, per-channel disagreement
// flags and a saturating count of non-unanimous samples.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_STABLE  | raw majority agrees with vote_out, run_q is 0
// ST_PENDING | raw majority differs from vote_out, run_q counts the run
module majority_voter_seq #(
  parameter int N     = 5,
  parameter int HOLD  = 3,
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  majority_voter_seq_if.slave  bus
);

  if ((N < 3) || (N > 31) || ((N % 2) == 0)) begin : g_bad_n
    $error("majority_voter_seq: N must be odd and within 3..31");
  end
  if ((HOLD < 1) || (HOLD > 255)) begin : g_bad_hold
    $error("majority_voter_seq: HOLD must be within 1..255");
  end
  if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cnt_w
    $error("majority_voter_seq: CNT_W must be within 1..32");
  end

  localparam int PW = $clog2(N + 1);
  localparam int RW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [PW-1:0]    HALF     = PW'((N - 1) / 2);
  localparam logic [RW-1:0]    RUN_LAST = RW'(HOLD - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

  typedef enum logic {ST_STABLE, ST_PENDING} state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    run_q, run_d;
  logic [RW-1:0]    warm_q, warm_d;
  logic             valid_q, valid_d;
  logic             vote_q, vote_d;
  logic             flip_q, flip_d;
  logic [N-1:0]     mism_q, mism_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic [PW-1:0]    pop;
  logic             maj;
  logic             mixed;
  logic [RW-1:0]    run_cur;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + PW'(bus.in_vec[i]);
    end
  end

  assign maj     = (pop > HALF);
  assign mixed   = (|bus.in_vec) && !(&bus.in_vec);
  // run_q is only meaningful while a run is pending
  assign run_cur = (state_q == ST_PENDING) ? run_q : '0;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    warm_d  = warm_q;
    valid_d = valid_q;
    vote_d  = vote_q;
    flip_d  = 1'b0;
    mism_d  = mism_q;
    err_d   = err_q;

    if (bus.en) begin
      if (maj == vote_q) begin
        state_d = ST_STABLE;
        run_d   = '0;
      end else if (run_cur == RUN_LAST) begin
        vote_d  = maj;
        flip_d  = 1'b1;
        run_d   = '0;
        state_d = ST_STABLE;
      end else begin
        state_d = ST_PENDING;
        run_d   = run_cur + 1'b1;
      end

      mism_d = bus.in_vec ^ {N{maj}};

      if (mixed && (err_q != ERR_MAX)) begin
        err_d = err_q + 1'b1;
      end

      if (!valid_q) begin
        if (warm_q == RUN_LAST) begin
          valid_d = 1'b1;
        end else begin
          warm_d = warm_q + 1'b1;
        end
      end
    end

    if (bus.clr_cnt) begin
      err_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STABLE;
      run_q   <= '0;
      warm_q  <= '0;
      valid_q <= 1'b0;
      vote_q  <= 1'b0;
      flip_q  <= 1'b0;
      mism_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      warm_q  <= warm_d;
      valid_q <= valid_d;
      vote_q  <= vote_d;
      flip_q  <= flip_d;
      mism_q  <= mism_d;
      err_q   <= err_d;
    end
  end

  assign bus.vote_out = vote_q;
  assign bus.valid    = valid_q;
  assign bus.flip     = flip_q;
  assign bus.mismatch = mism_q;
  assign bus.err_cnt  = err_q;

endmodule

// File: tb/tb_majority_voter_seq.sv
// Directed bench for majority_voter_seq (N=5, HOLD=3, CNT_W=4): the driver queues the
// expected post-edge outputs, the monitor pops and compares one entry per clock edge.
module tb_majority_voter_seq;

  logic clk;
  logic rst;

  majority_voter_seq_if #(.N(5), .CNT_W(4)) bus ();

  majority_voter_seq #(.N(5), .HOLD(3), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      nm;
    logic       vote;
    logic       valid;
    logic       flip;
    logic [4:0] mm;
    logic [3:0] err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mx;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h, required %0h", nm, fld, act, req);
    end
  endtask

  task automatic drive(input string nm, input logic r, input logic e, input logic c,
                       input logic [4:0] v, input logic ev, input logic evd,
                       input logic ef, input logic [4:0] em, input logic [3:0] ee);
    exp_t x;
    @(negedge clk);
    rst         = r;
    bus.en      = e;
    bus.clr_cnt = c;
    bus.in_vec  = v;
    x.nm    = nm;
    x.vote  = ev;
    x.valid = evd;
    x.flip  = ef;
    x.mm    = em;
    x.err   = ee;
    sb_q.push_back(x);
  endtask

  // monitor: one expected entry per clock edge, sampled just after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mx = sb_q.pop_front();
        chk(mx.nm, "vote_out", 32'(bus.vote_out), 32'(mx.vote));
        chk(mx.nm, "valid",    32'(bus.valid),    32'(mx.valid));
        chk(mx.nm, "flip",     32'(bus.flip),     32'(mx.flip));
        chk(mx.nm, "mismatch", 32'(bus.mismatch), 32'(mx.mm));
        chk(mx.nm, "err_cnt",  32'(bus.err_cnt),  32'(mx.err));
      end
    end
  end

  logic [4:0] vv;
  logic       m;
  logic       mixd;
  int         w;

  initial begin
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.clr_cnt = 1'b0;
    bus.in_vec  = '0;

    //     name        rst en clr vec        vote valid flip mm         err
    drive("reset",     1, 0, 0, 5'b00000,  0, 0, 0, 5'b00000, 4'd0);
    drive("rst_prio",  1, 1, 1, 5'b00111,  0, 0, 0, 5'b00000, 4'd0);
    // warm-up and first rise
    drive("rise_e1",   0, 1, 0, 5'b00111,  0, 0, 0, 5'b11000, 4'd1);
    drive("rise_e2",   0, 1, 0, 5'b00111,  0, 0, 0, 5'b11000, 4'd2);
    drive("rise_e3",   0, 1, 0, 5'b00111,  1, 1, 1, 5'b11000, 4'd3);
    // glitch rejection on the way down
    drive("glt_e1",    0, 1, 0, 5'b00011,  1, 1, 0, 5'b00011, 4'd4);
    drive("glt_e2",    0, 1, 0, 5'b00011,  1, 1, 0, 5'b00011, 4'd5);
    drive("glt_hit",   0, 1, 0, 5'b00111,  1, 1, 0, 5'b11000, 4'd6);
    drive("fall_e1",   0, 1, 0, 5'b00011,  1, 1, 0, 5'b00011, 4'd7);
    drive("fall_e2",   0, 1, 0, 5'b00011,  1, 1, 0, 5'b00011, 4'd8);
    drive("fall_e3",   0, 1, 0, 5'b00011,  0, 1, 1, 5'b00011, 4'd9);
    drive("fall_hold", 0, 1, 0, 5'b00011,  0, 1, 0, 5'b00011, 4'd10);
    // run spanning disabled cycles
    drive("gap_e1",    0, 1, 0, 5'b11100,  0, 1, 0, 5'b00011, 4'd11);
    drive("gap_d1",    0, 0, 0, 5'b11100,  0, 1, 0, 5'b00011, 4'd11);
    drive("gap_d2",    0, 0, 0, 5'b11100,  0, 1, 0, 5'b00011, 4'd11);
    drive("gap_e2",    0, 1, 0, 5'b11100,  0, 1, 0, 5'b00011, 4'd12);
    drive("gap_d3",    0, 0, 0, 5'b11100,  0, 1, 0, 5'b00011, 4'd12);
    drive("gap_e3",    0, 1, 0, 5'b11100,  1, 1, 1, 5'b00011, 4'd13);
    drive("gap_d4",    0, 0, 0, 5'b11100,  1, 1, 0, 5'b00011, 4'd13);
    drive("clr_noen",  0, 0, 1, 5'b00001,  1, 1, 0, 5'b00011, 4'd0);

    // saturation of err_cnt while the vote also falls
    for (int k = 1; k <= 20; k++) begin
      drive("sat", 0, 1, 0, 5'b00001, (k < 3), 1'b1, (k == 3), 5'b00001,
            (k < 15) ? 4'(k) : 4'd15);
    end
    drive("clr_prio",  0, 1, 1, 5'b00001,  0, 1, 0, 5'b00001, 4'd0);
    drive("post_clr",  0, 1, 0, 5'b00001,  0, 1, 0, 5'b00001, 4'd1);

    // reset in the middle of a run discards it
    drive("abort_e1",  0, 1, 0, 5'b11111,  0, 1, 0, 5'b00000, 4'd1);
    drive("abort_rst", 1, 1, 0, 5'b11111,  0, 0, 0, 5'b00000, 4'd0);
    drive("redo_e1",   0, 1, 0, 5'b11111,  0, 0, 0, 5'b00000, 4'd0);
    drive("redo_e2",   0, 1, 0, 5'b11111,  0, 0, 0, 5'b00000, 4'd0);
    drive("redo_e3",   0, 1, 0, 5'b11111,  1, 1, 1, 5'b00000, 4'd0);

    // every input pattern from a freshly reset voter
    for (int v = 0; v < 32; v++) begin
      vv   = 5'(v);
      m    = ($countones(vv) >= 3);
      mixd = (vv != 5'b00000) && (vv != 5'b11111);
      drive("exh_rst", 1, 0, 0, 5'b00000, 0, 0, 0, 5'b00000, 4'd0);
      for (int k = 1; k <= 3; k++) begin
        drive("exh", 0, 1, 0, vv, (k == 3) && m, (k == 3), (k == 3) && m,
              vv ^ {5{m}}, mixd ? 4'(k) : 4'd0);
      end
    end

    w = 0;
    while ((sb_q.size() > 0) && (w < 20)) begin
      @(posedge clk);
      #2;
      w++;
    end
    if (sb_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/majority_voter_seq.md
MAJORITY_VOTER_SEQ -- requirements
Module: majority_voter_seq

Interface
REQ-001 SHALL have parameter N, default 5: number of voter inputs; odd, 3..31; other values are a compile-time error.
REQ-002 SHALL have parameter HOLD, default 3: consecutive enabled cycles a new majority must persist before vote_out changes; 1..255.
REQ-003 SHALL have parameter CNT_W, default 8: width of err_cnt; 1..32.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-006 SHALL have port en  input  1  sample enable; 0 freezes all state except the clr_cnt path.
REQ-007 SHALL have port in_vec  input  N  voter inputs, one bit per channel.
REQ-008 SHALL have port clr_cnt  input  1  synchronous clear of err_cnt.
REQ-009 SHALL have port vote_out  output  1  filtered, registered majority decision.
REQ-010 SHALL have port valid  output  1  vote_out qualified; set after warm-up.
REQ-011 SHALL have port flip  output  1  one-cycle pulse on the edge where vote_out changes.
REQ-012 SHALL have port mismatch  output  N  registered per-channel disagreement with the raw majority.
REQ-013 SHALL have port err_cnt  output  CNT_W  saturating count of non-unanimous enabled samples.

Function
REQ-014 Raw majority maj SHALL be 1 iff popcount(in_vec) > (N-1)/2; popcount width SHALL be $clog2(N+1) bits with no overflow.
REQ-015 Filter SHALL be a two-state FSM: STABLE (maj == vote_out) and PENDING (maj != vote_out, run_cnt counting).
REQ-016 On an enabled edge with maj == vote_out: state -> STABLE, run_cnt -> 0, vote_out unchanged.
REQ-017 On an enabled edge with maj != vote_out and run_cnt < HOLD-1: state -> PENDING, run_cnt increments.
REQ-018 On an enabled edge with maj != vote_out and run_cnt == HOLD-1: vote_out -> maj, flip -> 1 for that cycle, run_cnt -> 0, state -> STABLE.
REQ-019 Latency SHALL be: vote_out updates at the HOLD-th consecutive enabled edge that samples the differing majority; HOLD=1 gives a plain one-cycle registered majority.
REQ-020 A single enabled sample with maj == vote_out during PENDING SHALL abort the run (glitch rejection).
REQ-021 Disabled cycles (en=0) SHALL neither advance nor reset run_cnt; a run spanning disabled cycles continues when en returns.
REQ-022 flip SHALL be 0 in every cycle other than the one defined in REQ-018, including all en=0 cycles.
REQ-023 mismatch[i] SHALL register (in_vec[i] != maj) on each enabled edge and hold otherwise.
REQ-024 err_cnt SHALL increment by 1 on each enabled edge where in_vec is neither all-0 nor all-1, saturating at 2^CNT_W-1 with no wrap.
REQ-025 clr_cnt SHALL set err_cnt to 0 on the next edge regardless of en, with priority over a same-cycle increment.
REQ-026 valid SHALL rise on the HOLD-th enabled edge after reset and stay 1 until reset; the warm-up counter SHALL obey REQ-021.

Reset
REQ-027 rst SHALL have priority over en, clr_cnt and all other inputs.
REQ-028 On a reset edge: vote_out=0, valid=0, flip=0, mismatch=0, err_cnt=0, run_cnt=0, warm-up counter=0, state=STABLE.
REQ-029 Reset asserted mid-PENDING SHALL discard the run; no flip SHALL be produced for it.

Verification (N=5, HOLD=3, CNT_W=4)
REQ-030 rst 1 cycle, then en=1, in_vec=5'b00111 for 3 edges -> vote_out 1 and flip=1 after edge 3, valid=1 after edge 3, mismatch=5'b11000, err_cnt=3.
REQ-031 vote_out=1; in_vec=5'b00011 for 2 edges, 5'b00111 for 1 edge, 5'b00011 for 3 edges -> vote_out stays 1 through the glitch, falls after the final 3rd edge, exactly one flip pulse.
REQ-032 vote_out=0; in_vec=5'b11100 with en pattern 1,0,0,1,0,1 -> vote_out rises only on the 3rd enabled edge; flip=0 while en=0.
REQ-033 in_vec=5'b00001 with en=1 for 20 edges -> err_cnt saturates at 15; clr_cnt with en=1 and a non-unanimous sample -> err_cnt=0 next edge.
REQ-034 Assert rst on the 2nd edge of a 3-edge run toward 1 -> all outputs return to REQ-028 values; a following unanimous 5'b11111 needs 3 new edges to set vote_out.
REQ-035 Exhaustive: all 32 in_vec values held 3 enabled edges each from vote_out=0 -> vote_out == (popcount >= 3), checked against a reference model.
